dcache_2way_ctrl: RTL and testbench
===================================

Name: dcache_2way_ctrl

Overview:
- Parametrised 2-way set-associative, write-back, write-allocate data cache controller.
- Sits between the EX/MEM pipeline register (p1 side) and the line-wide off-chip data memory (mem side).
- Successor to the direct-mapped dcache: adds set count and line width parameters, 2-way associativity with per-set LRU replacement, and invalid-way-first victim selection.
- Tag, valid, dirty and LRU state are held in internal registers. Data lines are held in internal register arrays.

Parameters:
- ADDR_W, 32: byte-address width.
- WORD_W, 32: CPU word width.
- LINE_W, 256: cache line width and memory transfer width. Must be a power-of-2 multiple of WORD_W.
- SETS, 16: number of sets, power of 2.
- Derived: OFF_W = log2(LINE_W/8); IDX_W = log2(SETS); TAG_W = ADDR_W - IDX_W - OFF_W.

Ports:
- clk_i, input, 1: clock; all state updates on the rising edge.
- rst_i, input, 1: reset, asynchronous, active-low.
- p1_addr_i, input, ADDR_W: CPU byte address.
- p1_data_i, input, WORD_W: CPU store data.
- p1_MemRead_i, input, 1: load request.
- p1_MemWrite_i, input, 1: store request.
- p1_data_o, output, WORD_W: load data.
- p1_stall_o, output, 1: pipeline stall.
- mem_data_i, input, LINE_W: refill line from memory.
- mem_ack_i, input, 1: one-cycle completion pulse from memory.
- mem_data_o, output, LINE_W: write-back line.
- mem_addr_o, output, ADDR_W: line-aligned memory address (offset bits zero).
- mem_enable_o, output, 1: memory request.
- mem_write_o, output, 1: 1 = write-back, 0 = refill.

Behaviour:
- Address split: tag = [ADDR_W-1 : IDX_W+OFF_W]; index = [IDX_W+OFF_W-1 : OFF_W]; word select = [OFF_W-1 : log2(WORD_W/8)]. Low byte bits are ignored.
- Request: req = p1_MemRead_i | p1_MemWrite_i. If both are high, the access is a write.
- Lookup is combinational in IDLE. hit_w = valid_w & (tag_w == tag). At most one way hits.
- Read hit:
  - p1_data_o = selected word in the same cycle; p1_stall_o = 0.
  - LRU[index] is set to the other way at the clock edge.
- Write hit:
  - No stall.
  - At the edge: the word is written, dirty_w = 1, LRU updated.
- p1_data_o = 0 whenever there is no read hit in IDLE.
- Miss: p1_stall_o = 1 combinationally in the same cycle.
- Victim selection: way0 if invalid, else way1 if invalid, else the way given by LRU[index]. The victim is latched at the edge.
- FSM states:
  - IDLE: miss with dirty victim -> WRITEBACK; miss with clean or invalid victim -> ALLOCATE.
  - WRITEBACK:
    - mem_enable_o = 1, mem_write_o = 1.
    - mem_addr_o = {victim tag, index, 0}; mem_data_o = victim line.
    - On mem_ack_i -> GAP.
  - GAP: one cycle with mem_enable_o = 0 -> ALLOCATE.
  - ALLOCATE:
    - mem_enable_o = 1, mem_write_o = 0; mem_addr_o = {tag, index, 0}.
    - On mem_ack_i: victim line = mem_data_i, tag written, valid = 1, dirty = 0 -> IDLE.
    - The next cycle the access re-looks-up as a hit and stall drops.
- Memory outputs are registered from the state and latched request. They are stable for the whole transaction.
- mem_data_o = 0 outside WRITEBACK.
- p1_stall_o = 1 in every non-IDLE state.
- The CPU holds p1_* stable while stalled; the controller does not re-latch them mid-miss.
- No request in IDLE: no state change, p1_stall_o = 0, mem_enable_o = 0.
- mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
- Reset (rst_i = 0, any state, including mid-transaction):
  - All valid, dirty and LRU bits cleared; state = IDLE.
  - mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
  - p1_stall_o = 0, p1_data_o = 0.
  - Dirty data is discarded. Data arrays need not be cleared.

Test Plan:
- Defaults used: SETS = 16, LINE_W = 256, so index = addr[8:5] and word = addr[4:2].
1. Cold read of 0x48:
   - Required: stall = 1 the same cycle; next cycle mem_enable_o = 1, mem_write_o = 0, mem_addr_o = 0x40.
   - Memory acks after 10 cycles with line[95:64] = 0xDEADBEEF.
   - Required: the cycle after ack, stall = 0 and p1_data_o = 0xDEADBEEF.
2. Write 0x48 <- 0x12345678, then read 0x48:
   - Required: no stall, no mem_enable_o; read returns 0x12345678.
3. Read 0x248 (same set, tag 1):
   - Required: fills way1 with no write-back.
   - Required: read 0x48 then hits with no memory traffic.
4. Read 0x448 (LRU = way1, clean):
   - Required: way1 is replaced with no write-back.
   - Then read 0x248:
     - Required: victim is way0 (dirty, LRU) -> WRITEBACK with mem_addr_o = 0x40, mem_write_o = 1, mem_data_o[95:64] = 0x12345678.
     - Required: one GAP cycle with enable = 0, then ALLOCATE at 0x240.
5. Assert rst_i = 0 during ALLOCATE:
   - Required: mem_enable_o and p1_stall_o go to 0 immediately.
   - After release, read 0x48 misses (valid cleared).
6. Read and write both high at 0x84 with data 0xA5A5A5A5, cold:
   - Required: refill at 0x80, word written, dirty set.
   - A later eviction of that set writes back 0xA5A5A5A5 at line[63:32].

Source files
------------

// File: rtl/dcache_2way_ctrl.sv
// 2-way set-associative, write-back, write-allocate data cache controller.
// Lookup is combinational in IDLE; misses run WRITEBACK -> GAP -> ALLOCATE against a line-wide memory.
`timescale 1ns/1ps
module dcache_2way_ctrl #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [WORD_W-1:0] p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [WORD_W-1:0] p1_data_o,
    output logic              p1_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int BYTE_W = $clog2(WORD_W / 8);
    localparam int WSEL_W = OFF_W - BYTE_W;

    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_GAP, S_ALLOCATE} state_t;

    state_t               state_r, state_next_s;
    logic [TAG_W-1:0]     tag_r  [SETS][2];
    logic [LINE_W-1:0]    data_r [SETS][2];
    logic [1:0][SETS-1:0] valid_r, dirty_r;
    logic [SETS-1:0]      lru_r;
    logic                 victim_r;
    logic                 mem_enable_r, mem_write_r;
    logic [ADDR_W-1:0]    mem_addr_r;
    logic [LINE_W-1:0]    mem_data_r;

    logic [TAG_W-1:0]     tag_s;
    logic [IDX_W-1:0]     idx_s;
    logic [WSEL_W-1:0]    wsel_s;
    logic [1:0]           hit_way_s;
    logic                 req_s, hit_s, hit_w_s, miss_s, victim_s, vic_way_s;
    logic [WORD_W-1:0]    rd_word_s;
    logic                 mem_en_next_s, mem_wr_next_s;
    logic [ADDR_W-1:0]    mem_addr_next_s;
    logic [LINE_W-1:0]    mem_data_next_s;
    logic                 unused_byte_s;

    assign tag_s         = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign idx_s         = p1_addr_i[OFF_W +: IDX_W];
    assign wsel_s        = p1_addr_i[BYTE_W +: WSEL_W];
    assign unused_byte_s = ^p1_addr_i[BYTE_W-1:0];
    assign req_s         = p1_MemRead_i | p1_MemWrite_i;
    assign hit_s         = |hit_way_s;
    assign hit_w_s       = hit_way_s[1];
    assign miss_s        = req_s & ~hit_s;
    assign rd_word_s     = data_r[idx_s][hit_w_s][wsel_s*WORD_W +: WORD_W];
    // The victim is only free-running while IDLE; afterwards the latched choice is used.
    assign vic_way_s     = (state_r == S_IDLE) ? victim_s : victim_r;

    assign mem_enable_o  = mem_enable_r;
    assign mem_write_o   = mem_write_r;
    assign mem_addr_o    = mem_addr_r;
    assign mem_data_o    = mem_data_r;

    // Tag compare for both ways of the addressed set
    always_comb begin
        hit_way_s    = 2'b00;
        hit_way_s[0] = valid_r[0][idx_s] && (tag_r[idx_s][0] == tag_s);
        hit_way_s[1] = valid_r[1][idx_s] && (tag_r[idx_s][1] == tag_s);
    end

    // Victim choice: invalid way first, otherwise the least recently used way
    always_comb begin
        victim_s = 1'b0;
        if (!valid_r[0][idx_s]) begin
            victim_s = 1'b0;
        end else if (!valid_r[1][idx_s]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_r[idx_s];
        end
    end

    // Miss-handling state machine next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (miss_s) begin
                    if (valid_r[victim_s][idx_s] && dirty_r[victim_s][idx_s]) begin
                        state_next_s = S_WRITEBACK;
                    end else begin
                        state_next_s = S_ALLOCATE;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_WRITEBACK: begin
                if (mem_ack_i) begin
                    state_next_s = S_GAP;
                end else begin
                    state_next_s = S_WRITEBACK;
                end
            end
            S_GAP: state_next_s = S_ALLOCATE;
            S_ALLOCATE: begin
                if (mem_ack_i) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_ALLOCATE;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Memory request contents for the state being entered
    always_comb begin
        mem_en_next_s   = 1'b0;
        mem_wr_next_s   = 1'b0;
        mem_addr_next_s = {ADDR_W{1'b0}};
        mem_data_next_s = {LINE_W{1'b0}};
        case (state_next_s)
            S_WRITEBACK: begin
                mem_en_next_s   = 1'b1;
                mem_wr_next_s   = 1'b1;
                mem_addr_next_s = {tag_r[idx_s][vic_way_s], idx_s, {OFF_W{1'b0}}};
                mem_data_next_s = data_r[idx_s][vic_way_s];
            end
            S_ALLOCATE: begin
                mem_en_next_s   = 1'b1;
                mem_wr_next_s   = 1'b0;
                mem_addr_next_s = {tag_s, idx_s, {OFF_W{1'b0}}};
                mem_data_next_s = {LINE_W{1'b0}};
            end
            default: begin
                mem_en_next_s   = 1'b0;
                mem_wr_next_s   = 1'b0;
                mem_addr_next_s = {ADDR_W{1'b0}};
                mem_data_next_s = {LINE_W{1'b0}};
            end
        endcase
    end

    // CPU-side stall and load data; forced low while reset is asserted
    always_comb begin
        p1_stall_o = 1'b0;
        p1_data_o  = {WORD_W{1'b0}};
        if (!rst_i) begin
            p1_stall_o = 1'b0;
            p1_data_o  = {WORD_W{1'b0}};
        end else if (state_r != S_IDLE) begin
            p1_stall_o = 1'b1;
            p1_data_o  = {WORD_W{1'b0}};
        end else begin
            p1_stall_o = miss_s;
            if (p1_MemRead_i && !p1_MemWrite_i && hit_s) begin
                p1_data_o = rd_word_s;
            end else begin
                p1_data_o = {WORD_W{1'b0}};
            end
        end
    end

    // State, victim latch and valid/dirty/LRU bookkeeping
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r  <= S_IDLE;
            victim_r <= 1'b0;
            valid_r  <= {(2*SETS){1'b0}};
            dirty_r  <= {(2*SETS){1'b0}};
            lru_r    <= {SETS{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (state_r == S_IDLE) begin
                victim_r <= victim_s;
            end
            if (state_r == S_IDLE && req_s && hit_s) begin
                lru_r[idx_s] <= ~hit_w_s;
                if (p1_MemWrite_i) begin
                    dirty_r[hit_w_s][idx_s] <= 1'b1;
                end
            end
            if (state_r == S_ALLOCATE && mem_ack_i) begin
                valid_r[victim_r][idx_s] <= 1'b1;
                dirty_r[victim_r][idx_s] <= 1'b0;
            end
        end
    end

    // Registered memory interface so it holds steady across a transaction
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_enable_r <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_data_r   <= {LINE_W{1'b0}};
        end else begin
            mem_enable_r <= mem_en_next_s;
            mem_write_r  <= mem_wr_next_s;
            mem_addr_r   <= mem_addr_next_s;
            mem_data_r   <= mem_data_next_s;
        end
    end

    // Tag and data arrays; contents are meaningless until the valid bit is set
    always_ff @(posedge clk_i) begin
        if (state_r == S_IDLE && p1_MemWrite_i && hit_s) begin
            data_r[idx_s][hit_w_s][wsel_s*WORD_W +: WORD_W] <= p1_data_i;
        end else if (state_r == S_ALLOCATE && mem_ack_i) begin
            data_r[idx_s][victim_r] <= mem_data_i;
            tag_r[idx_s][victim_r]  <= tag_s;
        end
    end
endmodule

// File: tb/tb_dcache_2way_ctrl.sv
// Self-checking bench for dcache_2way_ctrl: vector table with a memory model and
// scoreboard queues for load data and memory transactions, plus a reset-mid-refill sequence.
`timescale 1ns/1ps
module tb_dcache_2way_ctrl;
    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  p1_addr, p1_wdata;
    logic         p1_rd, p1_wr;
    logic [31:0]  p1_rdata;
    logic         p1_stall;
    logic [255:0] mem_rdata, mem_wdata;
    logic         mem_ack;
    logic [31:0]  mem_addr;
    logic         mem_en, mem_we;

    always #5 clk = ~clk;

    dcache_2way_ctrl dut (
        .clk_i(clk), .rst_i(rst_n),
        .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
        .p1_MemRead_i(p1_rd), .p1_MemWrite_i(p1_wr),
        .p1_data_o(p1_rdata), .p1_stall_o(p1_stall),
        .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
        .mem_data_o(mem_wdata), .mem_addr_o(mem_addr),
        .mem_enable_o(mem_en), .mem_write_o(mem_we)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Backing memory: untouched lines hold a pattern derived from their address
    logic [255:0] mem_model [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] la, input int k);
        return {la[15:0], 16'(k)} ^ 32'h5A00_0000;
    endfunction

    function automatic logic [255:0] init_line(input logic [31:0] la);
        logic [255:0] l;
        l = {256{1'b0}};
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = init_word(la, k);
        return l;
    endfunction

    function automatic logic [255:0] fetch(input logic [31:0] la);
        if (mem_model.exists(la)) return mem_model[la];
        return init_line(la);
    endfunction

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  wsel;
        logic [31:0] word;
    } mem_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        logic [31:0] rdata;
        logic        miss;
        logic        wb;
        logic [31:0] wb_addr;
        logic [2:0]  wb_sel;
        logic [31:0] wb_word;
    } vec_t;

    mem_exp_t    mem_q[$];
    logic [31:0] rd_q[$];
    vec_t        vecs[13];

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] wd, input logic rd, input logic wr,
                                input logic [31:0] rdat, input logic miss, input logic wb,
                                input logic [31:0] wba, input logic [2:0] wbs, input logic [31:0] wbw);
        vec_t v;
        v.addr = a; v.wdata = wd; v.rd = rd; v.wr = wr; v.rdata = rdat; v.miss = miss;
        v.wb = wb; v.wb_addr = wba; v.wb_sel = wbs; v.wb_word = wbw;
        return v;
    endfunction

    // Called on a falling edge; returns on a falling edge with the request dropped
    task automatic run_access(input vec_t v);
        mem_exp_t    e;
        logic [31:0] cur_addr;
        int          cyc, lat;
        logic        prev_en, gap_due, done;
        p1_addr = v.addr; p1_wdata = v.wdata; p1_rd = v.rd; p1_wr = v.wr;
        if (v.wb) begin
            e.addr = v.wb_addr; e.wr = 1'b1; e.wsel = v.wb_sel; e.word = v.wb_word;
            mem_q.push_back(e);
        end
        if (v.miss) begin
            e.addr = v.addr & ~32'h1F; e.wr = 1'b0; e.wsel = 3'd0; e.word = 32'd0;
            mem_q.push_back(e);
        end
        if (v.rd && !v.wr) rd_q.push_back(v.rdata);
        #1;
        check("stall_first_cycle", p1_stall, v.miss);
        if (v.miss) check("data_zero_on_miss", p1_rdata, 32'd0);
        cyc = 0; lat = 0; prev_en = 1'b0; gap_due = 1'b0; done = 1'b0; cur_addr = 32'd0;
        while (!done) begin
            if (!p1_stall) begin
                done = 1'b1;
            end else begin
                if (cyc == 1) check("req_next_cycle", mem_en, 1'b1);
                if (gap_due) begin
                    check("gap_enable_low", mem_en, 1'b0);
                    gap_due = 1'b0;
                end
                if (mem_en) begin
                    if (!prev_en) begin
                        lat = 0;
                        cur_addr = mem_addr;
                        if (mem_q.size() == 0) begin
                            check("unexpected_mem_req", mem_addr, 32'hFFFF_FFFF);
                        end else begin
                            e = mem_q.pop_front();
                            check("mem_addr", mem_addr, e.addr);
                            check("mem_write", mem_we, e.wr);
                            if (e.wr) check("wb_word", mem_wdata[e.wsel*32 +: 32], e.word);
                        end
                    end
                    lat++;
                    if (lat == LAT) begin
                        check("mem_addr_stable", mem_addr, cur_addr);
                        if (mem_we) mem_model[mem_addr] = mem_wdata;
                        else mem_rdata = fetch(mem_addr);
                        mem_ack = 1'b1;
                        gap_due = mem_we;
                        lat = 0;
                    end
                end
                prev_en = mem_en;
                cyc++;
                if (cyc > 100) begin
                    check("stall_timeout", 1'b1, 1'b0);
                    done = 1'b1;
                end
            end
            if (!done) begin
                @(negedge clk);
                mem_ack = 1'b0;
                #1;
            end
        end
        if (v.rd && !v.wr && rd_q.size() > 0) check("load_data", p1_rdata, rd_q.pop_front());
        check("no_mem_on_hit", mem_en, 1'b0);
        check("pending_mem_txns", mem_q.size(), 0);
        mem_q.delete();
        @(posedge clk);
        @(negedge clk);
        p1_rd = 1'b0; p1_wr = 1'b0;
    endtask

    // Pull reset in the middle of a refill and confirm everything is discarded
    task automatic reset_mid_alloc();
        p1_addr = 32'h48; p1_rd = 1'b1; p1_wr = 1'b0;
        #1 check("rst_seq_miss", p1_stall, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        check("rst_seq_alloc_en", mem_en, 1'b1);
        check("rst_seq_alloc_we", mem_we, 1'b0);
        check("rst_seq_alloc_addr", mem_addr, 32'h40);
        rst_n = 1'b0;
        #1;
        check("rst_async_enable", mem_en, 1'b0);
        check("rst_async_stall", p1_stall, 1'b0);
        check("rst_async_addr", mem_addr, 32'd0);
        check("rst_async_data", p1_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("miss_after_reset", p1_stall, 1'b1);
        p1_rd = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [255:0] pre;
        pre = init_line(32'h40);
        pre[95:64] = 32'hDEAD_BEEF;
        mem_model[32'h40] = pre;

        vecs[0]  = mk(32'h048, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF,          1'b1, 1'b0, 32'h0,  3'd0, 32'h0);
        vecs[1]  = mk(32'h048, 32'h1234_5678, 1'b0, 1'b1, 32'h0,                  1'b0, 1'b0, 32'h0,  3'd0, 32'h0);
        vecs[2]  = mk(32'h048, 32'h0,         1'b1, 1'b0, 32'h1234_5678,          1'b0, 1'b0, 32'h0,  3'd0, 32'h0);
        vecs[3]  = mk(32'h248, 32'h0,         1'b1, 1'b0, init_word(32'h240, 2),  1'b1, 1'b0, 32'h0,  3'd0, 32'h0);
        vecs[4]  = mk(32'h048, 32'h0,         1'b1, 1'b0, 32'h1234_5678,          1'b0, 1'b0, 32'h0,  3'd0, 32'h0);
        vecs[5]  = mk(32'h448, 32'h0,         1'b1, 1'b0, init_word(32'h440, 2),  1'b1, 1'b0, 32'h0,  3'd0, 32'h0);
        vecs[6]  = mk(32'h248, 32'h0,         1'b1, 1'b0, init_word(32'h240, 2),  1'b1, 1'b1, 32'h40, 3'd2, 32'h1234_5678);
        vecs[7]  = mk(32'h048, 32'h0,         1'b1, 1'b0, 32'h1234_5678,          1'b1, 1'b0, 32'h0,  3'd0, 32'h0);
        vecs[8]  = mk(32'h084, 32'hA5A5_A5A5, 1'b1, 1'b1, 32'h0,                  1'b1, 1'b0, 32'h0,  3'd0, 32'h0);
        vecs[9]  = mk(32'h084, 32'h0,         1'b1, 1'b0, 32'hA5A5_A5A5,          1'b0, 1'b0, 32'h0,  3'd0, 32'h0);
        vecs[10] = mk(32'h284, 32'h0,         1'b1, 1'b0, init_word(32'h280, 1),  1'b1, 1'b0, 32'h0,  3'd0, 32'h0);
        vecs[11] = mk(32'h484, 32'h0,         1'b1, 1'b0, init_word(32'h480, 1),  1'b1, 1'b1, 32'h80, 3'd1, 32'hA5A5_A5A5);
        vecs[12] = mk(32'h084, 32'h0,         1'b1, 1'b0, 32'hA5A5_A5A5,          1'b1, 1'b0, 32'h0,  3'd0, 32'h0);

        rst_n = 1'b0; p1_addr = 32'h48; p1_wdata = 32'h0; p1_rd = 1'b1; p1_wr = 1'b0;
        mem_rdata = {256{1'b0}}; mem_ack = 1'b0;
        #1;
        check("reset_stall", p1_stall, 1'b0);
        check("reset_p1_data", p1_rdata, 32'd0);
        check("reset_mem_en", mem_en, 1'b0);
        check("reset_mem_we", mem_we, 1'b0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_data", mem_wdata, 256'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; p1_rd = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("idle_ack_ignored_en", mem_en, 1'b0);
        check("idle_no_stall", p1_stall, 1'b0);
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            if (i == 7) reset_mid_alloc();
            run_access(vecs[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
